// File: rtl/mem_write_buffer.sv
// mem_write_buffer: store queue between the MEM-stage write-data encoder and data memory
//   Stores are queued and drained over memReq/memAck. A store to the same word as the
//   newest (non-head) entry merges into it. Loads that hit a pending word raise rdHazard.
//   clk, resetN                       : clock, asynchronous active-low reset
//   wrValid/wrAddr/wrData/wrBe/wrReady: store request from MEM stage
//   rdValid/rdAddr/rdHazard           : load address check against pending stores
//   memReq/memAddr/memData/memBe/memAck: head entry presented to memory
//   empty/count                       : occupancy
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             wrValid,
    input  logic [31:0]      wrAddr,
    input  logic [31:0]      wrData,
    input  logic [3:0]       wrBe,
    output logic             wrReady,
    input  logic             rdValid,
    input  logic [31:0]      rdAddr,
    output logic             rdHazard,
    output logic             memReq,
    output logic [31:0]      memAddr,
    output logic [31:0]      memData,
    output logic [3:0]       memBe,
    input  logic             memAck,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    logic [PTR_W-1:0] head, tail, tail_m1;
    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             merge, push, pop, hit;
    logic             unused_bits;
    assign unused_bits = ^{wrAddr[1:0], rdAddr[1:0]};
    assign tail_m1 = tail - 1'b1;
    // the head may be in flight, so only a non-head newest entry (count>=2) is merged into
    assign merge   = wrValid && |wrBe && count >= CNT_W'(2) && wrAddr[31:2] == addr_q[tail_m1];
    assign push    = wrValid && |wrBe && !merge && count < FULL;
    assign pop     = memReq && memAck;
    assign wrReady = merge || count < FULL;
    assign empty   = count == '0;
    assign memReq  = !empty;
    assign memAddr = empty ? 32'h0 : {addr_q[head], 2'b00};
    assign memData = empty ? 32'h0 : data_q[head];
    assign memBe   = empty ? 4'h0 : be_q[head];
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | (valid[i] && addr_q[i] == rdAddr[31:2]);
        rdHazard = rdValid && hit;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (merge) begin
                // be bit k selects lane bits [31-8k -: 8]
                for (int k = 0; k < 4; k++)
                    if (wrBe[k]) data_q[tail_m1][31-8*k -: 8] <= wrData[31-8*k -: 8];
                be_q[tail_m1] <= be_q[tail_m1] | wrBe;
            end
            if (push) begin
                addr_q[tail] <= wrAddr[31:2];
                data_q[tail] <= wrData;
                be_q[tail]   <= wrBe;
                valid[tail]  <= 1'b1;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: directed vector and sequence checks for mem_write_buffer
module tb_mem_write_buffer;
    logic        clk = 1'b0;
    logic        resetN;
    logic        wrValid, rdValid, memAck;
    logic [31:0] wrAddr, wrData, rdAddr;
    logic [3:0]  wrBe;
    logic        wrReady, rdHazard, memReq, empty;
    logic [31:0] memAddr, memData;
    logic [3:0]  memBe;
    logic [2:0]  count;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        wv;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  wb;
        logic        rv;
        logic [31:0] ra;
        logic        ack;
        logic        x_rdy;
        logic        x_hz;
        logic        x_req;
        logic [31:0] x_addr;
        logic [31:0] x_data;
        logic [3:0]  x_be;
        logic [2:0]  x_cnt;
    } vec_t;
    vec_t vecs[$];

    mem_write_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .resetN(resetN),
        .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData), .wrBe(wrBe), .wrReady(wrReady),
        .rdValid(rdValid), .rdAddr(rdAddr), .rdHazard(rdHazard),
        .memReq(memReq), .memAddr(memAddr), .memData(memData), .memBe(memBe), .memAck(memAck),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic wv, logic [31:0] wa, logic [31:0] wd, logic [3:0] wb,
                                logic rv, logic [31:0] ra, logic ack,
                                logic rdy, logic hz, logic req, logic [31:0] a,
                                logic [31:0] d, logic [3:0] be, logic [2:0] cnt);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.wb = wb; v.rv = rv; v.ra = ra; v.ack = ack;
        v.x_rdy = rdy; v.x_hz = hz; v.x_req = req; v.x_addr = a; v.x_data = d;
        v.x_be = be; v.x_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] wb, input logic rv, input logic [31:0] ra,
                         input logic ack);
        wrValid = wv; wrAddr = wa; wrData = wd; wrBe = wb;
        rdValid = rv; rdAddr = ra; memAck = ack;
    endtask

    initial begin
        // pre-edge columns: wrReady, rdHazard; post-edge columns: req, addr, data, be, count
        vecs.push_back(mk(1, 32'h100, 32'hAABBCCDD, 4'hF, 0, 0, 0, 1, 0, 1, 32'h100, 32'hAABBCCDD, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h100, 32'hAABBCCDD, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 32'hDD000000, 4'h1, 0, 0, 0, 1, 0, 1, 32'h200, 32'hDD000000, 4'h1, 1));
        vecs.push_back(mk(1, 32'h204, 32'h00DD0000, 4'h2, 0, 0, 0, 1, 0, 1, 32'h200, 32'hDD000000, 4'h1, 2));
        vecs.push_back(mk(1, 32'h204, 32'h0000DD00, 4'h4, 0, 0, 0, 1, 0, 1, 32'h200, 32'hDD000000, 4'h1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h204, 32'h00DDDD00, 4'h6, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h400, 32'h1, 4'hF, 0, 0, 0, 1, 0, 1, 32'h400, 32'h1, 4'hF, 1));
        vecs.push_back(mk(1, 32'h410, 32'h2, 4'hF, 0, 0, 0, 1, 0, 1, 32'h400, 32'h1, 4'hF, 2));
        vecs.push_back(mk(1, 32'h420, 32'h3, 4'hF, 0, 0, 0, 1, 0, 1, 32'h400, 32'h1, 4'hF, 3));
        vecs.push_back(mk(1, 32'h430, 32'h4, 4'hF, 0, 0, 0, 1, 0, 1, 32'h400, 32'h1, 4'hF, 4));
        vecs.push_back(mk(1, 32'h440, 32'h5, 4'hF, 0, 0, 0, 0, 0, 1, 32'h400, 32'h1, 4'hF, 4));
        vecs.push_back(mk(1, 32'h432, 32'h44, 4'hF, 0, 0, 0, 1, 0, 1, 32'h400, 32'h1, 4'hF, 4));
        vecs.push_back(mk(1, 32'h500, 32'h9, 4'hF, 0, 0, 1, 0, 0, 1, 32'h410, 32'h2, 4'hF, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h410, 32'h2, 4'hF, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h420, 32'h3, 4'hF, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h430, 32'h44, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h600, 32'h77, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h300, 32'h11, 4'hF, 1, 32'h302, 0, 1, 0, 1, 32'h300, 32'h11, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h302, 0, 1, 1, 1, 32'h300, 32'h11, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h304, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h302, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h900, 32'hAA000000, 4'h1, 0, 0, 0, 1, 0, 1, 32'h900, 32'hAA000000, 4'h1, 1));
        vecs.push_back(mk(1, 32'h904, 32'h00BB0000, 4'h2, 0, 0, 0, 1, 0, 1, 32'h900, 32'hAA000000, 4'h1, 2));
        vecs.push_back(mk(1, 32'h904, 32'h000000CC, 4'h8, 1, 32'h904, 1, 1, 1, 1, 32'h904, 32'h00BB00CC, 4'hA, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

        resetN = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_req", 32'(memReq), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_count", 32'(count), 32'h0);
        check("rst_addr", memAddr, 32'h0);
        check("rst_data", memData, 32'h0);
        check("rst_be", 32'(memBe), 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        check("rst_ready", 32'(wrReady), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].wb, vecs[i].rv, vecs[i].ra, vecs[i].ack);
            #1;
            check($sformatf("v%0d_ready", i), 32'(wrReady), 32'(vecs[i].x_rdy));
            check($sformatf("v%0d_hazard", i), 32'(rdHazard), 32'(vecs[i].x_hz));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_req", i), 32'(memReq), 32'(vecs[i].x_req));
            check($sformatf("v%0d_addr", i), memAddr, vecs[i].x_addr);
            check($sformatf("v%0d_data", i), memData, vecs[i].x_data);
            check($sformatf("v%0d_be", i), 32'(memBe), 32'(vecs[i].x_be));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].x_cnt));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].x_cnt == 3'd0));
        end

        // streaming: each cycle pushes store i and acks store i-1
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            drive(i < 6, 32'h800 + 32'(16 * i), 32'hA0 + 32'(i), 4'hF, 0, 0, 1);
            #1;
            if (i > 0) begin
                check($sformatf("s%0d_req", i), 32'(memReq), 32'h1);
                check($sformatf("s%0d_addr", i), memAddr, 32'h800 + 32'(16 * (i - 1)));
                check($sformatf("s%0d_data", i), memData, 32'hA0 + 32'(i - 1));
            end
            @(posedge clk);
            #1;
            check($sformatf("s%0d_count", i), 32'(count), i < 6 ? 32'h1 : 32'h0);
        end
        check("s_end_empty", 32'(empty), 32'h1);

        // asynchronous reset with three pending stores
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 32'hA00 + 32'(16 * i), 32'(i), 4'hF, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("ar_pre_count", 32'(count), 32'h3);
        check("ar_pre_req", 32'(memReq), 32'h1);
        #1;
        resetN = 1'b0;
        #1;
        check("ar_req", 32'(memReq), 32'h0);
        check("ar_empty", 32'(empty), 32'h1);
        check("ar_count", 32'(count), 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        check("ar_post_req", 32'(memReq), 32'h0);
        check("ar_post_ready", 32'(wrReady), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
